// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step counter must hold 0..width inclusive.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_mult.sv
// Radix-2 sequential multiplier: signed operands are reduced to magnitudes on
// acceptance, multiplied by shift-add, and the sign is restored at the end.
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   ina,
    input  logic [WIDTH-1:0]   inb,
    input  logic               signed_mode,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [2*WIDTH-1:0] outd,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int CW = cnt_width(WIDTH);
    localparam int PW = 2 * WIDTH;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic            neg_q, neg_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   step_q, step_d;
    logic [PW-1:0]   outd_q, outd_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;

    logic [WIDTH-1:0] mplier_sh;
    logic [PW-1:0]    addend;
    logic [PW-1:0]    sum;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        neg_d       = neg_q;
        acc_d       = acc_q;
        step_d      = step_q;
        outd_d      = outd_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;

        mplier_sh = mplier_q >> step_q;
        addend    = {{WIDTH{1'b0}}, mcand_q} << step_q;
        sum       = acc_q + addend;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Negating -2^(WIDTH-1) in WIDTH bits yields 2^(WIDTH-1), exact as unsigned.
                    mcand_d    = (signed_mode && ina[WIDTH-1]) ? -ina : ina;
                    mplier_d   = (signed_mode && inb[WIDTH-1]) ? -inb : inb;
                    neg_d      = signed_mode & (ina[WIDTH-1] ^ inb[WIDTH-1]);
                    acc_d      = '0;
                    step_d     = '0;
                    in_ready_d = 1'b0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (step_q == CW'(WIDTH)) begin
                    // Final cycle: sign restoration and product register load.
                    outd_d      = neg_q ? -acc_q : acc_q;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    if (mplier_sh[0]) begin
                        acc_d = sum;
                    end
                    step_d = step_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // NOTE: all registers, datapath included, are reset so an aborted operation leaves no trace.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            neg_q       <= 1'b0;
            acc_q       <= '0;
            step_q      <= '0;
            outd_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so all flops update from the same pre-edge values.
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            neg_q       <= neg_d;
            acc_q       <= acc_d;
            step_q      <= step_d;
            outd_q      <= outd_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign outd      = outd_q;

endmodule

// File: tb/tb_seq_mult.sv
// Directed and exhaustive checks of seq_mult at WIDTH=4 plus a WIDTH=8 instance.
module tb_seq_mult;

    logic        clk;
    logic        rst_n;
    logic [7:0]  ina;
    logic [7:0]  inb;
    logic        signed_mode;
    logic        iv;
    logic        out_ready;
    logic        sel8;

    logic        ir4, ov4, ir8, ov8;
    logic [7:0]  od4;
    logic [15:0] od8;

    logic        ir, ov;
    logic [15:0] od;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        m;
        int          w;
        logic [15:0] exp;
        string       name;
    } vec_t;

    seq_mult #(.WIDTH(4)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .ina        (ina[3:0]),
        .inb        (inb[3:0]),
        .signed_mode(signed_mode),
        .in_valid   (iv & ~sel8),
        .in_ready   (ir4),
        .outd       (od4),
        .out_valid  (ov4),
        .out_ready  (out_ready)
    );

    seq_mult #(.WIDTH(8)) u_dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .ina        (ina),
        .inb        (inb),
        .signed_mode(signed_mode),
        .in_valid   (iv & sel8),
        .in_ready   (ir8),
        .outd       (od8),
        .out_valid  (ov8),
        .out_ready  (out_ready)
    );

    assign ir = sel8 ? ir8 : ir4;
    assign ov = sel8 ? ov8 : ov4;
    assign od = sel8 ? od8 : {8'h00, od4};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_mult(input logic [7:0] a, input logic [7:0] b,
                                             input logic m, input int w);
        longint sa, sb, p, mask;
        sa = longint'(a) & ((longint'(1) << w) - 1);
        sb = longint'(b) & ((longint'(1) << w) - 1);
        if (m && a[w-1]) sa = sa - (longint'(1) << w);
        if (m && b[w-1]) sb = sb - (longint'(1) << w);
        p    = sa * sb;
        mask = (longint'(1) << (2 * w)) - 1;
        return 16'(p & mask);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; operands are scrambled during BUSY and in_valid
    // is pulsed while the result is held for 'hold' cycles.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic m,
                          input int w, input logic [15:0] exp, input string nm,
                          input int hold);
        int n;
        int lat;
        sel8 = (w == 8);
        #0;
        n = 0;
        while (!ir && n < 20) begin
            tick();
            n++;
        end
        check({nm, " in_ready"}, 32'(ir), 32'd1);
        ina = a;
        inb = b;
        signed_mode = m;
        iv = 1'b1;
        tick();
        iv = 1'b0;
        lat = 0;
        while (!ov && lat < 3 * w + 10) begin
            ina = 8'($urandom);
            inb = 8'($urandom);
            signed_mode = 1'($urandom);
            iv = 1'($urandom);
            tick();
            lat++;
        end
        iv = 1'b0;
        check({nm, " latency"}, 32'(lat), 32'(w + 1));
        check({nm, " outd"}, 32'(od), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            iv = 1'(i % 2);
            ina = 8'($urandom);
            inb = 8'($urandom);
            tick();
            check({nm, " hold"}, {od, 13'd0, ov, ir, 1'b0}, {exp, 13'd0, 1'b1, 1'b0, 1'b0});
        end
        iv = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({nm, " idle"}, {od, 14'd0, ov, ir}, {exp, 14'd0, 1'b0, 1'b1});
    endtask

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{8'h0F, 8'h0F, 1'b0, 4, 16'h00E1, "u4 15*15"};
        vecs[1]  = '{8'h08, 8'h08, 1'b1, 4, 16'h0040, "s4 -8*-8"};
        vecs[2]  = '{8'h08, 8'h07, 1'b1, 4, 16'h00C8, "s4 -8*7"};
        vecs[3]  = '{8'h03, 8'h0E, 1'b1, 4, 16'h00FA, "s4 3*-2"};
        vecs[4]  = '{8'h00, 8'h0D, 1'b0, 4, 16'h0000, "u4 0*13"};
        vecs[5]  = '{8'h0D, 8'h00, 1'b1, 4, 16'h0000, "s4 -3*0"};
        vecs[6]  = '{8'h08, 8'h08, 1'b0, 4, 16'h0040, "u4 8*8"};
        vecs[7]  = '{8'h0F, 8'h0F, 1'b1, 4, 16'h0001, "s4 -1*-1"};
        vecs[8]  = '{8'h07, 8'h08, 1'b1, 4, 16'h00C8, "s4 7*-8"};
        vecs[9]  = '{8'hFF, 8'hFF, 1'b0, 8, 16'hFE01, "u8 255*255"};
        vecs[10] = '{8'h80, 8'h80, 1'b1, 8, 16'h4000, "s8 -128*-128"};
        vecs[11] = '{8'h80, 8'h7F, 1'b1, 8, 16'hC080, "s8 -128*127"};
        vecs[12] = '{8'hFF, 8'h02, 1'b1, 8, 16'hFFFE, "s8 -1*2"};
        vecs[13] = '{8'hFF, 8'h02, 1'b0, 8, 16'h01FE, "u8 255*2"};

        rst_n = 1'b0;
        ina = '0;
        inb = '0;
        signed_mode = 1'b0;
        iv = 1'b0;
        out_ready = 1'b0;
        sel8 = 1'b0;
        repeat (3) tick();
        check("reset w4", {od, 14'd0, ov, ir}, {16'h0000, 14'd0, 1'b0, 1'b1});
        sel8 = 1'b1;
        #1;
        check("reset w8", {od, 14'd0, ov, ir}, {16'h0000, 14'd0, 1'b0, 1'b1});
        sel8 = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].w, vecs[i].exp, vecs[i].name,
                   (i == 0) ? 10 : 1);
        end

        // Abort mid-BUSY, then the next operation must start clean on the first edge.
        sel8 = 1'b0;
        ina = 8'd5;
        inb = 8'd3;
        signed_mode = 1'b0;
        iv = 1'b1;
        tick();
        iv = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        check("abort during reset", {od, 14'd0, ov, ir}, {16'h0000, 14'd0, 1'b0, 1'b1});
        tick();
        rst_n = 1'b1;
        #1;
        check("abort after release", {od, 14'd0, ov, ir}, {16'h0000, 14'd0, 1'b0, 1'b1});
        run_op(8'd6, 8'd5, 1'b0, 4, 16'h001E, "u4 6*5 post-abort", 0);

        for (int m = 0; m < 2; m++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    run_op(8'(a), 8'(b), 1'(m), 4, ref_mult(8'(a), 8'(b), 1'(m), 4),
                           "exh w4", $urandom_range(0, 2));
                end
            end
        end

        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra, rb;
            logic       rm;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rm = 1'($urandom);
            run_op(ra, rb, rm, 8, ref_mult(ra, rb, rm, 8), "rand w8", $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
